// File: rtl/cbus_aging_arbiter_pkg.sv
// rtl/cbus_aging_arbiter_pkg.sv - CBus request/response types and arbiter state/defaults
package cbus_aging_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [3:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic        err;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cbus_arb_state_t;

  localparam int CBUS_ARB_AGE_MAX = 15;

  // Index width that stays legal when there is a single requester.
  function automatic int cbus_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_aging_arbiter_age_prio_picker.sv
// rtl/cbus_aging_arbiter_age_prio_picker.sv - combinational fixed-priority picker with age promotion
module age_prio_picker
  import cbus_aging_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = CBUS_ARB_AGE_MAX,
  parameter int IDX_W   = cbus_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ-1:0][AGE_W-1:0] i_age,
  output logic [IDX_W-1:0]              o_winner,
  output logic                          o_any_valid
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  // Scan downward so the lowest qualifying index is written last; aged requesters override.
  always_comb begin
    o_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_valid[i]) o_winner = IDX_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_age[i] >= AGE_SAT)) o_winner = IDX_W'(i);
    end
    o_any_valid = |i_valid;
  end

endmodule

// File: rtl/cbus_aging_arbiter.sv
// rtl/cbus_aging_arbiter.sv - CBus master arbiter: aging priority, whole-transaction grants, hang watchdog
module cbus_aging_arbiter
  import cbus_aging_arbiter_pkg::*;
#(
  parameter int   NUM_REQ = 2,
  parameter int   AGE_W   = 4,
  parameter int   AGE_MAX = CBUS_ARB_AGE_MAX,
  parameter int   TO_W    = 16,
  localparam int  IDX_W   = cbus_idx_w(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout_err
);

  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(AGE_MAX);
  localparam logic [TO_W-1:0]  WDOG_MAX = '1;

  cbus_arb_state_t               r_state;
  logic [IDX_W-1:0]              r_grant_idx;
  logic [NUM_REQ-1:0][AGE_W-1:0] r_age;
  logic [TO_W-1:0]               r_wdog;
  logic                          r_timeout;

  logic [NUM_REQ-1:0] w_valid;
  logic [IDX_W-1:0]   w_winner;
  logic               w_any_valid;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_valid[i] = ireqs[i].valid;
  end

  age_prio_picker #(
    .NUM_REQ (NUM_REQ),
    .AGE_W   (AGE_W),
    .AGE_MAX (AGE_MAX),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_valid     (w_valid),
    .i_age       (r_age),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_age       <= '0;
      r_wdog      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_any_valid) begin
            r_state     <= BUSY;
            r_grant_idx <= w_winner;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (IDX_W'(i) == w_winner) r_age[i] <= '0;
              else if (!w_valid[i])      r_age[i] <= '0;
              else if (r_age[i] < AGE_SAT) r_age[i] <= r_age[i] + 1'b1;
            end
          end
        end
        BUSY: begin
          if (oresp.ready) begin
            r_wdog <= '0;
            if (oresp.last) r_state <= IDLE;
          end else begin
            // Saturate rather than wrap; the hung transaction is left in place for debug.
            if (r_wdog != WDOG_MAX) r_wdog <= r_wdog + 1'b1;
            if (r_wdog >= WDOG_MAX - 1'b1) r_timeout <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    oreq = '0;
    if (r_state == BUSY) oreq = ireqs[r_grant_idx];
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
      if ((r_state == BUSY) && (IDX_W'(i) == r_grant_idx)) iresps[i] = oresp;
    end
  end

  assign busy        = (r_state == BUSY);
  assign grant_idx   = r_grant_idx;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_cbus_aging_arbiter.sv
// tb/tb_cbus_aging_arbiter.sv - directed bench with a transaction-level arbiter model
module tb_cbus_aging_arbiter;
  import cbus_aging_arbiter_pkg::*;

  localparam int AGE_MAX = 3;
  localparam int STALL_LIMIT = 15;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs  [2];
  cbus_resp_t iresps [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] grant_idx;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  cbus_aging_arbiter #(
    .NUM_REQ (2),
    .AGE_W   (2),
    .AGE_MAX (AGE_MAX),
    .TO_W    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ireqs       (ireqs),
    .iresps      (iresps),
    .oreq        (oreq),
    .oresp       (oresp),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 when no transaction is held, else the master index.
  int m_owner = -1;
  int m_grant = 0;
  int m_age [2] = '{0, 0};
  int m_stall = 0;
  bit m_to = 0;
  bit m_live = 0;

  always @(posedge clk) begin
    int w;
    w = -1;
    if (!reset) begin
      m_owner = -1; m_grant = 0; m_age = '{0, 0}; m_stall = 0; m_to = 0; m_live = 1;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 2; i++) if (w < 0 && ireqs[i].valid && m_age[i] == AGE_MAX) w = i;
      for (int i = 0; i < 2; i++) if (w < 0 && ireqs[i].valid) w = i;
      if (w >= 0) begin
        for (int i = 0; i < 2; i++) begin
          if (i == w) m_age[i] = 0;
          else if (ireqs[i].valid) m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
          else m_age[i] = 0;
        end
        m_owner = w; m_grant = w; m_stall = 0;
      end
    end else if (oresp.ready) begin
      m_stall = 0;
      if (oresp.last) m_owner = -1;
    end else begin
      if (m_stall < STALL_LIMIT) m_stall++;
      if (m_stall >= STALL_LIMIT) m_to = 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      cbus_req_t exp_req;
      exp_req = (m_owner >= 0) ? ireqs[m_owner] : '0;
      check("m_oreq", 128'(oreq), 128'(exp_req));
      for (int i = 0; i < 2; i++)
        check($sformatf("m_iresps%0d", i), 128'(iresps[i]), (m_owner == i) ? 128'(oresp) : 128'(0));
      check("m_busy", 128'(busy), 128'(m_owner >= 0));
      check("m_grant_idx", 128'(grant_idx), 128'(m_grant));
      check("m_timeout", 128'(timeout_err), 128'(m_to));
      check("m_age0", 128'(dut.r_age[0]), 128'(m_age[0]));
      check("m_age1", 128'(dut.r_age[1]), 128'(m_age[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic rdy, input logic lst);
    oresp = '0;
    oresp.ready = rdy;
    oresp.last = lst;
    oresp.rdata = 32'hCAFE_0000 | 32'(n_checks & 16'hFFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0;
    ireqs[0] = '0; ireqs[1] = '0; oresp = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant", 128'(grant_idx), 128'(0));
    check("rst_timeout", 128'(timeout_err), 128'(0));

    // Single request from master 1
    ireqs[1].valid = 1'b1; ireqs[1].addr = 32'h8000_0000; ireqs[1].len = 4'd0;
    #2;
    check("single_grant_cycle_valid", 128'(oreq.valid), 128'(0));
    step();
    check("single_oreq_valid", 128'(oreq.valid), 128'(1));
    check("single_oreq_addr", 128'(oreq.addr), 128'(32'h8000_0000));
    check("single_grant_idx", 128'(grant_idx), 128'(1));
    step();
    resp(1'b1, 1'b1);
    #2;
    check("single_resp_ready", 128'(iresps[1].ready), 128'(1));
    check("single_other_zero", 128'(iresps[0]), 128'(0));
    step();
    check("single_busy_fall", 128'(busy), 128'(0));
    ireqs[1] = '0; oresp = '0;
    step();

    // Simultaneous requests
    ireqs[0].valid = 1'b1; ireqs[0].addr = 32'h100;
    ireqs[1].valid = 1'b1; ireqs[1].addr = 32'h200;
    step();
    check("simul_first_grant", 128'(grant_idx), 128'(0));
    check("simul_first_addr", 128'(oreq.addr), 128'(32'h100));
    resp(1'b1, 1'b1);
    #2;
    check("simul_loser_ready", 128'(iresps[1].ready), 128'(0));
    step();
    check("simul_gap_busy", 128'(busy), 128'(0));
    ireqs[0] = '0; oresp = '0;
    step();
    check("simul_second_grant", 128'(grant_idx), 128'(1));
    check("simul_second_addr", 128'(oreq.addr), 128'(32'h200));
    resp(1'b1, 1'b1);
    step();
    ireqs[1] = '0; oresp = '0;
    step();

    // Burst hold: master 0 four beats while master 1 waits
    ireqs[0].valid = 1'b1; ireqs[0].addr = 32'h300; ireqs[0].len = 4'd3;
    ireqs[1].valid = 1'b1; ireqs[1].addr = 32'h400;
    step();
    for (int b = 0; b < 4; b++) begin
      resp(1'b1, b == 3);
      #2;
      check("burst_beat_addr", 128'(oreq.addr), 128'(32'h300));
      check("burst_beat_loser", 128'(iresps[1].ready), 128'(0));
      step();
      if (b < 3) check("burst_hold_busy", 128'(busy), 128'(1));
    end
    check("burst_release", 128'(busy), 128'(0));
    ireqs[0] = '0; oresp = '0;
    step();
    check("burst_next_grant", 128'(grant_idx), 128'(1));
    resp(1'b1, 1'b1);
    step();
    ireqs[1] = '0; oresp = '0;
    step();

    // Starvation: master 0 re-requests continuously
    ireqs[0].valid = 1'b1; ireqs[0].addr = 32'h10;
    ireqs[1].valid = 1'b1; ireqs[1].addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      step();
      check("starve_grant", 128'(grant_idx), (k == 3) ? 128'(1) : 128'(0));
      if (k == 3) begin
        check("starve_age1", 128'(dut.r_age[1]), 128'(0));
        check("starve_age0", 128'(dut.r_age[0]), 128'(1));
      end
      resp(1'b1, 1'b1);
      step();
      oresp = '0;
    end
    ireqs[0] = '0; ireqs[1] = '0;
    step();

    // Watchdog with a 4-bit counter
    ireqs[0].valid = 1'b1; ireqs[0].addr = 32'h500;
    step();
    for (int s = 1; s <= 15; s++) begin
      step();
      check("wdog_timeout", 128'(timeout_err), (s == 15) ? 128'(1) : 128'(0));
    end
    repeat (3) step();
    resp(1'b1, 1'b1);
    step();
    check("wdog_done_busy", 128'(busy), 128'(0));
    check("wdog_sticky", 128'(timeout_err), 128'(1));
    ireqs[0] = '0; oresp = '0;
    step();
    reset = 1'b0;
    step();
    check("wdog_cleared", 128'(timeout_err), 128'(0));
    reset = 1'b1;
    step();

    // Reset mid-burst
    ireqs[1].valid = 1'b1; ireqs[1].addr = 32'h600; ireqs[1].len = 4'd3;
    step();
    resp(1'b1, 1'b0);
    step();
    resp(1'b1, 1'b0);
    reset = 1'b0;
    step();
    check("rstmid_oreq_valid", 128'(oreq.valid), 128'(0));
    check("rstmid_busy", 128'(busy), 128'(0));
    check("rstmid_timeout", 128'(timeout_err), 128'(0));
    reset = 1'b1; ireqs[1] = '0; oresp = '0;
    step();
    ireqs[0].valid = 1'b1; ireqs[0].addr = 32'h700;
    step();
    check("rstmid_fresh_busy", 128'(busy), 128'(1));
    check("rstmid_fresh_addr", 128'(oreq.addr), 128'(32'h700));
    resp(1'b1, 1'b1);
    step();
    ireqs[0] = '0; oresp = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
